mem_wb_multi: RTL and testbench
===============================

Name: mem_wb_multi

Overview:
- Parametrised MEM→WB pipeline register for the multi-issue core. Carries LANES parallel GPR writeback lanes, plus scalar HI/LO, LL-bit and CP0 write ports.
- Handles stall bubbles, flush, and the multi-cycle MEM counter of configurable width.
- Adds per-lane valid bits, same-cycle write-collision resolution and $zero write suppression.
- Adds a retired-instruction counter.
- Sits between the MEM stage and regfile/hilo/cp0/llbit write ports.

Parameters:
- LANES, 2, number of writeback lanes (1..4); lane LANES-1 is the youngest.
- DATA_W, 32, GPR/HI/LO/CP0 data width.
- ADDR_W, 5, GPR address width.
- CP0_ADDR_W, 5, CP0 register address width.
- CNT_W, 2, MEM multi-cycle counter width.
- STALL_W, 6, width of the pipeline stall vector.
- STAGE, 4, stall-vector index of this stage; index STAGE+1 is the downstream stage.
- RET_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- stall  in  STALL_W  pipeline stall vector; 1 = Stop
- flush  in  1  exception flush
- mem_valid  in  LANES  per-lane instruction valid
- mem_wd  in  LANES*ADDR_W  per-lane destination register, lane i at bits [i*ADDR_W +: ADDR_W]
- mem_wreg  in  LANES  per-lane GPR write enable
- mem_wdata  in  LANES*DATA_W  per-lane write data
- mem_whilo  in  1  HI/LO write enable
- mem_hi, mem_lo  in  DATA_W  HI/LO data
- mem_llbit_we, mem_llbit_value  in  1  LL-bit write
- mem_cp0_reg_we  in  1  CP0 write enable
- mem_cp0_reg_write_addr  in  CP0_ADDR_W  CP0 write address
- mem_cp0_reg_data  in  DATA_W  CP0 write data
- cnt_i  in  CNT_W  MEM multi-cycle counter
- wb_valid, wb_wd, wb_wreg, wb_wdata  out  same widths as inputs  registered lane outputs
- wb_whilo, wb_hi, wb_lo, wb_llbit_we, wb_llbit_value, wb_cp0_reg_we, wb_cp0_reg_write_addr, wb_cp0_reg_data  out  as inputs  registered scalar outputs
- cnt_o  out  CNT_W  registered counter
- retired_cnt  out  RET_W  retired-instruction count

Behaviour:
- All state updates on the rising edge of clk. One-cycle latency from inputs to outputs.
- Mode priority per edge: rst > flush > bubble > advance > hold.
- rst=1: every output clears to 0, including retired_cnt and cnt_o.
- flush=1: every output except retired_cnt clears to 0. cnt_o=0. retired_cnt holds.
- Bubble (stall[STAGE]=1, stall[STAGE+1]=0): all wb_* and wb_valid clear to 0. cnt_o<=cnt_i. retired_cnt holds.
- Advance (stall[STAGE]=0): outputs capture the filtered inputs (below). cnt_o<=0. retired_cnt <= retired_cnt + popcount(mem_valid), modulo 2^RET_W.
- Hold (stall[STAGE]=1, stall[STAGE+1]=1): every output holds except cnt_o<=cnt_i.
- Lane filter, applied at capture only:
  - Effective write enable for lane i: we_i = mem_valid[i] & mem_wreg[i] & (mem_wd_i != 0).
  - Collision: if a younger lane j>i has we_j and mem_wd_j == mem_wd_i, we_i is cleared. The youngest writer wins.
  - wb_wd and wb_wdata are captured unfiltered. wb_wreg carries the filtered enable.
- Invalid lanes: mem_valid[i]=0 forces wb_wreg[i]=0 and is not counted in retired_cnt.
- Scalar ports (HI/LO, LL-bit, CP0) are captured unchanged on advance. Their validity is the MEM stage's responsibility.
- If STAGE+1 >= STALL_W, the downstream bit is treated as 0 (NoStop).
- LANES=1 degenerates to a single-issue MEM/WB register plus valid and retire count.

Decomposition:
- Shared defines: RstEnable, Stop/NoStop, WriteEnable/WriteDisable, NOPRegAddr, ZeroWord (existing macros).
- New constant MEMWB_MAX_LANES=4 in the defines file.
- One combinational sub-module, wb_lane_filter: valid / $zero / collision masking, output LANES enables. Instantiated once.
- Popcount is a local function.

Test Plan (LANES=2, STAGE=4):
- Reset: rst=1 with arbitrary inputs → all outputs 0, retired_cnt=0. After rst=0 and one advance with valid=2'b11, wd={3,2}, wreg=2'b11 → wb_wreg=2'b11, retired_cnt=2.
- Collision: lanes 0 and 1 both write r7 with data 0x11 / 0x22, valid=2'b11 → wb_wreg=2'b10, wb_wdata lane1=0x22, retired_cnt +2.
- $zero write and invalid lane: lane0 wd=0, wreg=1; lane1 valid=0, wreg=1 → wb_wreg=2'b00, retired_cnt +1.
- Bubble vs hold: stall=6'b011111 with cnt_i=2 → wb_* cleared, cnt_o=2. Then stall=6'b111111, cnt_i=3 → wb_* unchanged, cnt_o=3, retired_cnt unchanged.
- Flush mid-stall: stall=6'b111111, flush=1 → wb_* cleared, cnt_o=0, retired_cnt unchanged.
- Wrap-around: RET_W=4, preload 15 via 15 single-lane advances, then advance with valid=2'b11 → retired_cnt=1.

Source files
------------

// File: rtl/mem_wb_multi_pkg.sv
// Shared constants and types for the multi-issue MEM/WB pipeline register.
// These constants replace the legacy define macros used in the older single-issue register.
package mem_wb_multi_pkg;

    localparam logic        RST_ENABLE      = 1'b1;
    localparam logic        STOP            = 1'b1;
    localparam logic        NO_STOP         = 1'b0;
    localparam logic        WRITE_ENABLE    = 1'b1;
    localparam logic        WRITE_DISABLE   = 1'b0;
    localparam logic [4:0]  NOP_REG_ADDR    = 5'b00000;
    localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;
    localparam int          MEMWB_MAX_LANES = 4;

    // Reset is not listed here because it is applied directly in the register block.
    typedef enum logic [1:0] {
        MODE_FLUSH,
        MODE_BUBBLE,
        MODE_ADVANCE,
        MODE_HOLD
    } mode_e;

endpackage

// File: rtl/mem_wb_multi_if.sv
// Bundles the MEM-side inputs and the WB-side registered outputs of mem_wb_multi.
// The master modport is the MEM stage. The slave modport is the pipeline register.
interface mem_wb_multi_if #(
    parameter int LANES      = 2,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int CP0_ADDR_W = 5,
    parameter int CNT_W      = 2,
    parameter int STALL_W    = 6,
    parameter int RET_W      = 32
) ();
    logic [STALL_W-1:0]      stall;
    logic                    flush;
    logic [LANES-1:0]        mem_valid;
    logic [LANES*ADDR_W-1:0] mem_wd;
    logic [LANES-1:0]        mem_wreg;
    logic [LANES*DATA_W-1:0] mem_wdata;
    logic                    mem_whilo;
    logic [DATA_W-1:0]       mem_hi;
    logic [DATA_W-1:0]       mem_lo;
    logic                    mem_llbit_we;
    logic                    mem_llbit_value;
    logic                    mem_cp0_reg_we;
    logic [CP0_ADDR_W-1:0]   mem_cp0_reg_write_addr;
    logic [DATA_W-1:0]       mem_cp0_reg_data;
    logic [CNT_W-1:0]        cnt_i;

    logic [LANES-1:0]        wb_valid;
    logic [LANES*ADDR_W-1:0] wb_wd;
    logic [LANES-1:0]        wb_wreg;
    logic [LANES*DATA_W-1:0] wb_wdata;
    logic                    wb_whilo;
    logic [DATA_W-1:0]       wb_hi;
    logic [DATA_W-1:0]       wb_lo;
    logic                    wb_llbit_we;
    logic                    wb_llbit_value;
    logic                    wb_cp0_reg_we;
    logic [CP0_ADDR_W-1:0]   wb_cp0_reg_write_addr;
    logic [DATA_W-1:0]       wb_cp0_reg_data;
    logic [CNT_W-1:0]        cnt_o;
    logic [RET_W-1:0]        retired_cnt;

    modport master (
        output stall, flush, mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo,
               mem_hi, mem_lo, mem_llbit_we, mem_llbit_value, mem_cp0_reg_we,
               mem_cp0_reg_write_addr, mem_cp0_reg_data, cnt_i,
        input  wb_valid, wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
               wb_llbit_we, wb_llbit_value, wb_cp0_reg_we, wb_cp0_reg_write_addr,
               wb_cp0_reg_data, cnt_o, retired_cnt
    );

    modport slave (
        input  stall, flush, mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo,
               mem_hi, mem_lo, mem_llbit_we, mem_llbit_value, mem_cp0_reg_we,
               mem_cp0_reg_write_addr, mem_cp0_reg_data, cnt_i,
        output wb_valid, wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
               wb_llbit_we, wb_llbit_value, wb_cp0_reg_we, wb_cp0_reg_write_addr,
               wb_cp0_reg_data, cnt_o, retired_cnt
    );
endinterface

// File: rtl/mem_wb_multi_wb_lane_filter.sv
// Combinational per-lane GPR write-enable filter.
// A lane is cleared if it is invalid, if it targets $zero, or if a younger lane writes the same register.
module wb_lane_filter
    import mem_wb_multi_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int ADDR_W = 5
) (
    input  logic [LANES-1:0]        valid_i,
    input  logic [LANES-1:0]        wreg_i,
    input  logic [LANES*ADDR_W-1:0] wd_i,
    output logic [LANES-1:0]        we_o
);
    logic [LANES-1:0] raw_we;

    always_comb begin
        raw_we = '0;
        we_o   = '0;
        for (int i = 0; i < LANES; i++) begin
            raw_we[i] = valid_i[i] && (wreg_i[i] == WRITE_ENABLE) &&
                        (wd_i[i*ADDR_W +: ADDR_W] != ADDR_W'(NOP_REG_ADDR));
        end
        // The youngest writer of a register wins. Older writers to the same register are masked.
        for (int i = 0; i < LANES; i++) begin
            we_o[i] = raw_we[i];
            for (int j = i + 1; j < LANES; j++) begin
                if (raw_we[j] && (wd_i[j*ADDR_W +: ADDR_W] == wd_i[i*ADDR_W +: ADDR_W])) begin
                    we_o[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/mem_wb_multi.sv
// MEM->WB pipeline register for the multi-issue core. It has LANES GPR writeback lanes, HI/LO, LL-bit and CP0 ports.
// It also handles the stall bubble, flush, the multi-cycle counter passthrough, and a retired-instruction count.
module mem_wb_multi
    import mem_wb_multi_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int CP0_ADDR_W = 5,
    parameter int CNT_W      = 2,
    parameter int STALL_W    = 6,
    parameter int STAGE      = 4,
    parameter int RET_W      = 32
) (
    input logic           clk,
    input logic           rst,
    mem_wb_multi_if.slave bus
);
    if (LANES < 1 || LANES > MEMWB_MAX_LANES) begin : g_lanes_check
        $error("mem_wb_multi: LANES out of range");
    end

    function automatic logic [RET_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [RET_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            sum = sum + RET_W'(v[i]);
        end
        return sum;
    endfunction

    logic [LANES-1:0]        we_filt;
    logic                    down_stall;
    logic                    unused_stall_bits;
    mode_e                   mode;

    logic [LANES-1:0]        valid_q, valid_d;
    logic [LANES*ADDR_W-1:0] wd_q, wd_d;
    logic [LANES-1:0]        wreg_q, wreg_d;
    logic [LANES*DATA_W-1:0] wdata_q, wdata_d;
    logic                    whilo_q, whilo_d;
    logic [DATA_W-1:0]       hi_q, hi_d;
    logic [DATA_W-1:0]       lo_q, lo_d;
    logic                    llbit_we_q, llbit_we_d;
    logic                    llbit_value_q, llbit_value_d;
    logic                    cp0_we_q, cp0_we_d;
    logic [CP0_ADDR_W-1:0]   cp0_addr_q, cp0_addr_d;
    logic [DATA_W-1:0]       cp0_data_q, cp0_data_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [RET_W-1:0]        ret_q, ret_d;

    wb_lane_filter #(
        .LANES (LANES),
        .ADDR_W(ADDR_W)
    ) u_lane_filter (
        .valid_i(bus.mem_valid),
        .wreg_i (bus.mem_wreg),
        .wd_i   (bus.mem_wd),
        .we_o   (we_filt)
    );

    // If there is no downstream stage in the stall vector, treat it as never stalled.
    if (STAGE + 1 < STALL_W) begin : g_down
        assign down_stall = bus.stall[STAGE+1];
    end else begin : g_no_down
        assign down_stall = NO_STOP;
    end

    assign unused_stall_bits = ^bus.stall;

    always_comb begin
        if (bus.flush) begin
            mode = MODE_FLUSH;
        end else if (bus.stall[STAGE] == NO_STOP) begin
            mode = MODE_ADVANCE;
        end else if (down_stall == STOP) begin
            mode = MODE_HOLD;
        end else begin
            mode = MODE_BUBBLE;
        end
    end

    always_comb begin
        valid_d       = valid_q;
        wd_d          = wd_q;
        wreg_d        = wreg_q;
        wdata_d       = wdata_q;
        whilo_d       = whilo_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        llbit_we_d    = llbit_we_q;
        llbit_value_d = llbit_value_q;
        cp0_we_d      = cp0_we_q;
        cp0_addr_d    = cp0_addr_q;
        cp0_data_d    = cp0_data_q;
        cnt_d         = cnt_q;
        ret_d         = ret_q;
        case (mode)
            MODE_FLUSH, MODE_BUBBLE: begin
                valid_d       = '0;
                wd_d          = '0;
                wreg_d        = {LANES{WRITE_DISABLE}};
                wdata_d       = '0;
                whilo_d       = WRITE_DISABLE;
                hi_d          = DATA_W'(ZERO_WORD);
                lo_d          = DATA_W'(ZERO_WORD);
                llbit_we_d    = WRITE_DISABLE;
                llbit_value_d = 1'b0;
                cp0_we_d      = WRITE_DISABLE;
                cp0_addr_d    = '0;
                cp0_data_d    = DATA_W'(ZERO_WORD);
                // A bubble keeps tracking the multi-cycle counter, but a flush abandons it.
                cnt_d         = (mode == MODE_BUBBLE) ? bus.cnt_i : '0;
            end
            MODE_ADVANCE: begin
                valid_d       = bus.mem_valid;
                wd_d          = bus.mem_wd;
                wreg_d        = we_filt;
                wdata_d       = bus.mem_wdata;
                whilo_d       = bus.mem_whilo;
                hi_d          = bus.mem_hi;
                lo_d          = bus.mem_lo;
                llbit_we_d    = bus.mem_llbit_we;
                llbit_value_d = bus.mem_llbit_value;
                cp0_we_d      = bus.mem_cp0_reg_we;
                cp0_addr_d    = bus.mem_cp0_reg_write_addr;
                cp0_data_d    = bus.mem_cp0_reg_data;
                cnt_d         = '0;
                ret_d         = ret_q + popcount(bus.mem_valid);
            end
            default: begin
                cnt_d = bus.cnt_i;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            valid_q       <= '0;
            wd_q          <= '0;
            wreg_q        <= '0;
            wdata_q       <= '0;
            whilo_q       <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
            llbit_we_q    <= 1'b0;
            llbit_value_q <= 1'b0;
            cp0_we_q      <= 1'b0;
            cp0_addr_q    <= '0;
            cp0_data_q    <= '0;
            cnt_q         <= '0;
            ret_q         <= '0;
        end else begin
            valid_q       <= valid_d;
            wd_q          <= wd_d;
            wreg_q        <= wreg_d;
            wdata_q       <= wdata_d;
            whilo_q       <= whilo_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            llbit_we_q    <= llbit_we_d;
            llbit_value_q <= llbit_value_d;
            cp0_we_q      <= cp0_we_d;
            cp0_addr_q    <= cp0_addr_d;
            cp0_data_q    <= cp0_data_d;
            cnt_q         <= cnt_d;
            ret_q         <= ret_d;
        end
    end

    assign bus.wb_valid              = valid_q;
    assign bus.wb_wd                 = wd_q;
    assign bus.wb_wreg               = wreg_q;
    assign bus.wb_wdata              = wdata_q;
    assign bus.wb_whilo              = whilo_q;
    assign bus.wb_hi                 = hi_q;
    assign bus.wb_lo                 = lo_q;
    assign bus.wb_llbit_we           = llbit_we_q;
    assign bus.wb_llbit_value        = llbit_value_q;
    assign bus.wb_cp0_reg_we         = cp0_we_q;
    assign bus.wb_cp0_reg_write_addr = cp0_addr_q;
    assign bus.wb_cp0_reg_data       = cp0_data_q;
    assign bus.cnt_o                 = cnt_q;
    assign bus.retired_cnt           = ret_q;

endmodule

// File: tb/tb_mem_wb_multi.sv
// Self-checking bench for mem_wb_multi with LANES=2, STAGE=4 and a 4-bit retire counter, so wrap-around can be exercised.
module tb_mem_wb_multi;
    localparam int LANES = 2, DATA_W = 32, ADDR_W = 5, CP0_ADDR_W = 5;
    localparam int CNT_W = 2, STALL_W = 6, STAGE = 4, RET_W = 4;

    typedef struct packed {
        logic [LANES-1:0]        valid;
        logic [LANES*ADDR_W-1:0] wd;
        logic [LANES-1:0]        wreg;
        logic [LANES*DATA_W-1:0] wdata;
        logic                    whilo;
        logic [DATA_W-1:0]       hi;
        logic [DATA_W-1:0]       lo;
        logic                    llwe;
        logic                    llv;
        logic                    cp0we;
        logic [CP0_ADDR_W-1:0]   cp0addr;
        logic [DATA_W-1:0]       cp0data;
        logic [CNT_W-1:0]        cnt;
        logic [RET_W-1:0]        ret;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_wb_multi_if #(
        .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CP0_ADDR_W(CP0_ADDR_W),
        .CNT_W(CNT_W), .STALL_W(STALL_W), .RET_W(RET_W)
    ) bus ();

    mem_wb_multi #(
        .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CP0_ADDR_W(CP0_ADDR_W),
        .CNT_W(CNT_W), .STALL_W(STALL_W), .STAGE(STAGE), .RET_W(RET_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    exp_t model;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour. Collisions are resolved by scanning from the youngest lane and claiming registers.
    function automatic exp_t model_next(input exp_t cur);
        exp_t             n = cur;
        logic [31:0]      claimed = '0;
        logic [LANES-1:0] we = '0;
        logic [ADDR_W-1:0] a;
        logic             raw;
        if (rst) begin
            n = '0;
        end else if (bus.flush) begin
            n = '0;
            n.ret = cur.ret;
        end else if (!bus.stall[STAGE]) begin
            for (int i = LANES - 1; i >= 0; i--) begin
                a = bus.mem_wd[i*ADDR_W +: ADDR_W];
                raw = bus.mem_valid[i] && bus.mem_wreg[i] && (a != 0);
                we[i] = raw && !claimed[a];
                if (raw) claimed[a] = 1'b1;
            end
            n.valid = bus.mem_valid;  n.wd = bus.mem_wd;  n.wreg = we;  n.wdata = bus.mem_wdata;
            n.whilo = bus.mem_whilo;  n.hi = bus.mem_hi;  n.lo = bus.mem_lo;
            n.llwe = bus.mem_llbit_we;  n.llv = bus.mem_llbit_value;
            n.cp0we = bus.mem_cp0_reg_we;  n.cp0addr = bus.mem_cp0_reg_write_addr;
            n.cp0data = bus.mem_cp0_reg_data;
            n.cnt = '0;
            n.ret = cur.ret + RET_W'($countones(bus.mem_valid));
        end else if (!bus.stall[STAGE+1]) begin
            n = '0;
            n.cnt = bus.cnt_i;
            n.ret = cur.ret;
        end else begin
            n.cnt = bus.cnt_i;
        end
        return n;
    endfunction

    task automatic tick();
        exp_t e;
        model = model_next(model);
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("wb_valid", 64'(bus.wb_valid), 64'(e.valid));
        check_eq("wb_wd", 64'(bus.wb_wd), 64'(e.wd));
        check_eq("wb_wreg", 64'(bus.wb_wreg), 64'(e.wreg));
        check_eq("wb_wdata", 64'(bus.wb_wdata), 64'(e.wdata));
        check_eq("wb_whilo", 64'(bus.wb_whilo), 64'(e.whilo));
        check_eq("wb_hi", 64'(bus.wb_hi), 64'(e.hi));
        check_eq("wb_lo", 64'(bus.wb_lo), 64'(e.lo));
        check_eq("wb_llbit", 64'({bus.wb_llbit_we, bus.wb_llbit_value}), 64'({e.llwe, e.llv}));
        check_eq("wb_cp0_we", 64'(bus.wb_cp0_reg_we), 64'(e.cp0we));
        check_eq("wb_cp0_addr", 64'(bus.wb_cp0_reg_write_addr), 64'(e.cp0addr));
        check_eq("wb_cp0_data", 64'(bus.wb_cp0_reg_data), 64'(e.cp0data));
        check_eq("cnt_o", 64'(bus.cnt_o), 64'(e.cnt));
        check_eq("retired_cnt", 64'(bus.retired_cnt), 64'(e.ret));
    endtask

    task automatic drive_ctrl(input logic [STALL_W-1:0] s, input logic f, input logic [CNT_W-1:0] c);
        bus.stall = s;
        bus.flush = f;
        bus.cnt_i = c;
    endtask

    task automatic drive_lanes(input logic [1:0] v, input logic [4:0] wd1, input logic [4:0] wd0,
                               input logic [1:0] wr, input logic [31:0] d1, input logic [31:0] d0);
        bus.mem_valid = v;
        bus.mem_wd    = {wd1, wd0};
        bus.mem_wreg  = wr;
        bus.mem_wdata = {d1, d0};
    endtask

    task automatic drive_scalars_random();
        bus.mem_whilo              = 1'($urandom_range(0, 1));
        bus.mem_hi                 = $urandom;
        bus.mem_lo                 = $urandom;
        bus.mem_llbit_we           = 1'($urandom_range(0, 1));
        bus.mem_llbit_value        = 1'($urandom_range(0, 1));
        bus.mem_cp0_reg_we         = 1'($urandom_range(0, 1));
        bus.mem_cp0_reg_write_addr = 5'($urandom_range(0, 31));
        bus.mem_cp0_reg_data       = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RET_W-1:0] ret_before;
        rst = 1'b1;
        drive_ctrl(6'b000000, 1'b1, 2'd3);
        drive_lanes(2'b11, 5'd9, 5'd4, 2'b11, 32'hdead, 32'hbeef);
        drive_scalars_random();
        tick();
        tick();
        check_eq("reset_retired", 64'(bus.retired_cnt), 64'd0);
        check_eq("reset_wreg", 64'(bus.wb_wreg), 64'd0);

        rst = 1'b0;
        drive_ctrl(6'b000000, 1'b0, 2'd1);
        drive_lanes(2'b11, 5'd3, 5'd2, 2'b11, 32'hbbbb, 32'haaaa);
        tick();
        check_eq("adv_wreg", 64'(bus.wb_wreg), 64'b11);
        check_eq("adv_retired", 64'(bus.retired_cnt), 64'd2);
        check_eq("adv_cnt", 64'(bus.cnt_o), 64'd0);

        drive_lanes(2'b11, 5'd7, 5'd7, 2'b11, 32'h22, 32'h11);
        tick();
        check_eq("coll_wreg", 64'(bus.wb_wreg), 64'b10);
        check_eq("coll_wdata1", 64'(bus.wb_wdata[63:32]), 64'h22);
        check_eq("coll_retired", 64'(bus.retired_cnt), 64'd4);

        drive_lanes(2'b01, 5'd5, 5'd0, 2'b11, 32'h44, 32'h33);
        tick();
        check_eq("zero_inv_wreg", 64'(bus.wb_wreg), 64'b00);
        check_eq("zero_inv_retired", 64'(bus.retired_cnt), 64'd5);

        // Load valid data, hold it, then insert a bubble and hold the bubble.
        drive_lanes(2'b11, 5'd12, 5'd11, 2'b11, 32'h5555, 32'h6666);
        tick();
        drive_ctrl(6'b111111, 1'b0, 2'd3);
        drive_lanes(2'b11, 5'd1, 5'd1, 2'b11, 32'h1, 32'h2);
        drive_scalars_random();
        tick();
        check_eq("hold_wreg", 64'(bus.wb_wreg), 64'b11);
        check_eq("hold_cnt", 64'(bus.cnt_o), 64'd3);
        check_eq("hold_retired", 64'(bus.retired_cnt), 64'd7);
        drive_ctrl(6'b011111, 1'b0, 2'd2);
        tick();
        check_eq("bubble_valid", 64'(bus.wb_valid), 64'd0);
        check_eq("bubble_cnt", 64'(bus.cnt_o), 64'd2);
        drive_ctrl(6'b111111, 1'b0, 2'd3);
        tick();
        check_eq("hold2_cnt", 64'(bus.cnt_o), 64'd3);
        check_eq("hold2_retired", 64'(bus.retired_cnt), 64'd7);

        drive_ctrl(6'b000000, 1'b0, 2'd0);
        drive_lanes(2'b10, 5'd8, 5'd9, 2'b10, 32'h77, 32'h88);
        tick();
        ret_before = bus.retired_cnt;
        drive_ctrl(6'b111111, 1'b1, 2'd2);
        tick();
        check_eq("flush_wreg", 64'(bus.wb_wreg), 64'd0);
        check_eq("flush_cnt", 64'(bus.cnt_o), 64'd0);
        check_eq("flush_retired", 64'(bus.retired_cnt), 64'(ret_before));

        for (int k = 0; k < 60; k++) begin
            drive_ctrl(6'($urandom_range(0, 63)), ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)));
            drive_lanes(2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                        2'($urandom_range(0, 3)), $urandom, $urandom);
            drive_scalars_random();
            tick();
        end

        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_ctrl(6'b000000, 1'b0, 2'd0);
        for (int k = 0; k < 15; k++) begin
            drive_lanes(2'b01, 5'd6, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), $urandom, $urandom);
            tick();
        end
        check_eq("preload_retired", 64'(bus.retired_cnt), 64'd15);
        drive_lanes(2'b11, 5'd6, 5'd6, 2'b11, 32'h1, 32'h2);
        tick();
        check_eq("wrap_retired", 64'(bus.retired_cnt), 64'd1);
        check_eq("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
